// File: rtl/led_status_tx_pkg.sv
// led_status_tx_pkg: shared widths and serializer state encoding for the LED status return channel.
package led_status_tx_pkg;
    localparam int LED_W  = 4;
    localparam int BEAT_W = 2;
    typedef enum logic [1:0] {IDLE, BEAT_LO, BEAT_HI} txState_t;
endpackage

// File: rtl/led_status_tx_status_fifo.sv
// status_fifo: small circular FIFO of status words with occupancy count.
module status_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr, rdPtr;
    logic             doPush, doPop;
    assign full   = count == (AW+1)'(DEPTH);
    assign empty  = count == '0;
    assign doPop  = pop && !empty;
    // A pop frees the head slot, so a push into a full FIFO is still legal that cycle.
    assign doPush = push && (!full || doPop);
    assign dout   = mem[rdPtr];
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop) rdPtr <= rdPtr + 1'b1;
            count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
        end
    end
endmodule

// File: rtl/led_status_tx.sv
// led_status_tx: buffers LED state changes and returns each as two 2-bit beats over a valid/ready channel.
module led_status_tx
    import led_status_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [LED_W-1:0]              ledState,
    input  logic                          sampleEn,
    output logic                          outValid,
    input  logic                          ready,
    output logic [BEAT_W-1:0]             dataOut,
    output logic                          last,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);
    txState_t         state, stateNext;
    logic [LED_W-1:0] prevLed, word, headWord;
    logic             pushReq, pushOk, pop, full, empty;
    assign pushReq = sampleEn && (ledState != prevLed);
    // Pops use the registered occupancy, so a word pushed this cycle is only seen next cycle.
    assign pop     = (state == IDLE || (state == BEAT_HI && ready)) && !empty;
    assign pushOk  = pushReq && (!full || pop);
    status_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(LED_W)) fifo (
        .clk(clk),
        .rst(rstn),
        .push(pushOk),
        .pop(pop),
        .din(ledState),
        .dout(headWord),
        .full(full),
        .empty(empty),
        .count(fifoCount)
    );
    always_comb begin
        stateNext = state;
        outValid  = 1'b0;
        dataOut   = '0;
        last      = 1'b0;
        case (state)
            IDLE: stateNext = empty ? IDLE : BEAT_LO;
            BEAT_LO: begin
                outValid  = 1'b1;
                dataOut   = word[BEAT_W-1:0];
                stateNext = ready ? BEAT_HI : BEAT_LO;
            end
            BEAT_HI: begin
                outValid  = 1'b1;
                dataOut   = word[LED_W-1:BEAT_W];
                last      = 1'b1;
                stateNext = !ready ? BEAT_HI : (empty ? IDLE : BEAT_LO);
            end
            default: stateNext = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rstn) begin
            state    <= IDLE;
            prevLed  <= '0;
            word     <= '0;
            overflow <= 1'b0;
        end else begin
            state <= stateNext;
            if (pushReq) prevLed <= ledState;
            if (pop) word <= headWord;
            if (pushReq && !pushOk) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_led_status_tx.sv
// tb_led_status_tx: directed and random stimulus checked cycle by cycle against a queue-based reference model.
module tb_led_status_tx;
    localparam int D = 4;
    logic       clk = 1'b0;
    logic       rstn, sampleEn, ready;
    logic [3:0] ledState;
    logic       outValid, last, overflow;
    logic [1:0] dataOut;
    logic [2:0] fifoCount;
    int checks = 0;
    int errors = 0;
    logic [3:0] mq[$];
    int         ph;
    logic [3:0] cur, prev;
    bit         ovf;

    led_status_tx #(.FIFO_DEPTH(D)) dut (
        .clk(clk),
        .rstn(rstn),
        .ledState(ledState),
        .sampleEn(sampleEn),
        .outValid(outValid),
        .ready(ready),
        .dataOut(dataOut),
        .last(last),
        .overflow(overflow),
        .fifoCount(fifoCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: ph 0 = no word held, 1 = low half on the wire, 2 = high half on the wire.
    task automatic tick();
        bit         rs, rq, acc, pp;
        int         sz, nph;
        logic [3:0] l;
        rs  = rstn;
        l   = ledState;
        sz  = mq.size();
        rq  = sampleEn && (l != prev);
        pp  = (ph == 0 || (ph == 2 && ready)) && sz > 0;
        acc = rq && (sz < D || pp);
        nph = ph == 0 ? (sz > 0 ? 1 : 0) : ph == 1 ? (ready ? 2 : 1) : (ready ? (sz > 0 ? 1 : 0) : 2);
        @(posedge clk);
        #1;
        if (rs) begin
            mq.delete();
            ph   = 0;
            cur  = '0;
            prev = '0;
            ovf  = 0;
        end else begin
            if (pp) cur = mq.pop_front();
            if (acc) mq.push_back(l);
            if (rq) prev = l;
            if (rq && !acc) ovf = 1;
            ph = nph;
        end
        chk("outValid", outValid, ph != 0);
        chk("dataOut", dataOut, ph == 1 ? cur[1:0] : ph == 2 ? cur[3:2] : 2'b00);
        chk("last", last, ph == 2);
        chk("overflow", overflow, ovf);
        chk("fifoCount", fifoCount, mq.size());
    endtask

    task automatic change(input logic [3:0] v);
        ledState = v;
        sampleEn = 1'b1;
        tick();
        sampleEn = 1'b0;
    endtask

    task automatic doReset();
        rstn = 1'b1;
        tick();
        rstn = 1'b0;
    endtask

    initial begin
        ph = 0; cur = '0; prev = '0; ovf = 0;
        rstn = 1'b1; sampleEn = 1'b0; ready = 1'b0; ledState = '0;
        tick();
        chk("rst_valid", outValid, 1'b0);
        chk("rst_count", fifoCount, 3'd0);
        rstn = 1'b0;
        // Single word, latency N+2
        ready = 1'b1;
        change(4'b1010);
        chk("lat_n1_valid", outValid, 1'b0);
        tick();
        chk("lat_n2_valid", outValid, 1'b1);
        chk("lat_n2_data", dataOut, 2'b10);
        chk("lat_n2_last", last, 1'b0);
        tick();
        chk("lat_n3_data", dataOut, 2'b10);
        chk("lat_n3_last", last, 1'b1);
        tick();
        chk("lat_done", outValid, 1'b0);
        // Backpressure holds the low beat stable
        doReset();
        ready = 1'b0;
        change(4'b0110);
        tick();
        repeat (5) begin
            tick();
            chk("hold_data", dataOut, 2'b10);
        end
        ready = 1'b1;
        tick();
        chk("hold_next_data", dataOut, 2'b01);
        chk("hold_next_last", last, 1'b1);
        tick();
        // Overflow: one word in the serializer plus a full FIFO, then a drop
        doReset();
        ready = 1'b0;
        for (int i = 1; i <= 5; i++) change(4'(i));
        chk("ovf_full_count", fifoCount, 3'd4);
        chk("ovf_not_yet", overflow, 1'b0);
        change(4'b0110);
        chk("ovf_set", overflow, 1'b1);
        ready = 1'b1;
        repeat (14) tick();
        chk("ovf_sticky", overflow, 1'b1);
        chk("ovf_drained", outValid, 1'b0);
        // Back-to-back words stream without a gap
        doReset();
        ready = 1'b1;
        ledState = 4'b0001; sampleEn = 1'b1;
        tick();
        ledState = 4'b1111;
        tick();
        sampleEn = 1'b0;
        chk("b2b_beat1", {outValid, dataOut, last}, {1'b1, 2'b01, 1'b0});
        tick();
        chk("b2b_beat2", {outValid, dataOut, last}, {1'b1, 2'b00, 1'b1});
        tick();
        chk("b2b_beat3", {outValid, dataOut, last}, {1'b1, 2'b11, 1'b0});
        tick();
        chk("b2b_beat4", {outValid, dataOut, last}, {1'b1, 2'b11, 1'b1});
        tick();
        chk("b2b_idle", outValid, 1'b0);
        // Reset while in the high beat with two words buffered
        doReset();
        ready = 1'b0;
        change(4'b0011);
        change(4'b0101);
        change(4'b1001);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("mid_in_hi", last, 1'b1);
        chk("mid_buffered", fifoCount, 3'd2);
        doReset();
        chk("mid_valid", outValid, 1'b0);
        chk("mid_count", fifoCount, 3'd0);
        ready = 1'b1;
        repeat (4) tick();
        chk("mid_quiet", outValid, 1'b0);
        // Toggling with sampling disabled pushes nothing
        for (int i = 0; i < 6; i++) begin
            ledState = 4'(i * 5 + 3);
            tick();
        end
        chk("nosample_valid", outValid, 1'b0);
        chk("nosample_count", fifoCount, 3'd0);
        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rstn     = ($urandom_range(0, 63) == 0);
            sampleEn = $urandom_range(0, 1);
            ready    = ($urandom_range(0, 3) != 0);
            ledState = 4'($urandom_range(0, 3) == 0 ? prev : $urandom_range(0, 15));
            tick();
        end
        rstn = 1'b0; sampleEn = 1'b0; ready = 1'b1;
        repeat (12) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
